// File: rtl/cpu6_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// cpu6_pipeline_ctrl
//
// Hazard and sequencing controller for the cpu6 5-stage pipeline. It decides,
// each cycle, whether the front of the pipeline holds, which pipeline
// registers receive a bubble, and whether fetch is redirected.
//
// Hazard sources, highest priority first:
//   1. mem_busy           : data memory is not ready, so the whole pipe holds.
//   2. DRAIN / REDIRECT   : an empty-pipeline sequence is in progress.
//   3. jumpE              : taken jump/branch resolved in E.
//   4. load-use           : the load in E feeds rs1/rs2 of the instruction in D.
//
// Empty-pipeline sequence, started by a serialising instruction in MEM:
//   request cycle  : flush F/D/E, hold PC, capture pcplus4M.
//   DRAIN          : keep flushing for max(DRAIN_CYCLES,1) non-busy cycles.
//   REDIRECT       : one cycle that refetches from the captured PC.
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-high reset
//   rs1D, rs2D          in   source register indices of the D instruction
//   memtoregE           in   E instruction is a load
//   writeregE           in   destination register of the E instruction
//   jumpE               in   taken jump/branch resolved in E
//   jump_targetE        in   target address for jumpE
//   empty_pipeline_reqM in   serialising instruction is in MEM
//   pcplus4M            in   pc+4 of the MEM instruction
//   mem_busy            in   data memory not ready
//   stallF/D/E          out  hold PC, IF/ID, ID/EX
//   flashD/E/M          out  clear the IF/ID, ID/EX, EX/MEM inputs
//   redirect_valid      out  load PC from redirect_pc this cycle
//   redirect_pc         out  new fetch address (0 when redirect_valid is 0)
//   busy                out  empty-pipeline sequence in progress
// -----------------------------------------------------------------------------
module cpu6_pipeline_ctrl #(
   parameter int XLEN         = 32,
   parameter int RFIDX_WIDTH  = 5,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [RFIDX_WIDTH-1:0] rs1D,
   input  logic [RFIDX_WIDTH-1:0] rs2D,
   input  logic                   memtoregE,
   input  logic [RFIDX_WIDTH-1:0] writeregE,
   input  logic                   jumpE,
   input  logic [XLEN-1:0]        jump_targetE,
   input  logic                   empty_pipeline_reqM,
   input  logic [XLEN-1:0]        pcplus4M,
   input  logic                   mem_busy,
   output logic                   stallF,
   output logic                   stallD,
   output logic                   stallE,
   output logic                   flashD,
   output logic                   flashE,
   output logic                   flashM,
   output logic                   redirect_valid,
   output logic [XLEN-1:0]        redirect_pc,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DRAIN    = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   // A DRAIN_CYCLES of 0 still needs one drain cycle.
   localparam logic [3:0] LP_DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 4'd1 : 4'(DRAIN_CYCLES);

   logic [1:0]      r_state;
   logic [3:0]      r_cnt;
   logic [XLEN-1:0] r_saved_pc;
   logic            w_luse;

   // x0 is never a real destination, so a load to x0 cannot create a hazard.
   assign w_luse = memtoregE && (writeregE != '0) &&
                   ((writeregE == rs1D) || (writeregE == rs2D));

   // -- state / counter / saved PC ----------------------------------------
   // mem_busy freezes everything, which also defers a pending request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 4'd0;
         r_saved_pc <= '0;
      end else if (!mem_busy) begin
         case (r_state)
            ST_IDLE: begin
               if (empty_pipeline_reqM) begin
                  r_state    <= ST_DRAIN;
                  r_cnt      <= LP_DRAIN_LOAD;
                  r_saved_pc <= pcplus4M;
               end
            end
            ST_DRAIN: begin
               if (r_cnt <= 4'd1) begin
                  r_state <= ST_REDIRECT;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_REDIRECT: r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase
      end
   end

   // -- combinational controls ---------------------------------------------
   // Outputs are forced quiet while reset is held, regardless of inputs.
   always_comb begin
      stallF         = 1'b0;
      stallD         = 1'b0;
      stallE         = 1'b0;
      flashD         = 1'b0;
      flashE         = 1'b0;
      flashM         = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      busy           = 1'b0;
      if (!reset) begin
         busy = (r_state != ST_IDLE);
         if (mem_busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
         end else begin
            case (r_state)
               ST_DRAIN: begin
                  stallF = 1'b1;
                  flashD = 1'b1;
                  flashE = 1'b1;
                  flashM = 1'b1;
               end
               ST_REDIRECT: begin
                  redirect_valid = 1'b1;
                  redirect_pc    = r_saved_pc;
                  flashD         = 1'b1;
               end
               default: begin
                  // The serialising request wins over a jump in E: the
                  // jump is younger and is killed along with it.
                  if (empty_pipeline_reqM) begin
                     stallF = 1'b1;
                     flashD = 1'b1;
                     flashE = 1'b1;
                     flashM = 1'b1;
                  end else if (jumpE) begin
                     redirect_valid = 1'b1;
                     redirect_pc    = jump_targetE;
                     flashD         = 1'b1;
                     flashE         = 1'b1;
                  end else if (w_luse) begin
                     stallF = 1'b1;
                     stallD = 1'b1;
                     flashE = 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu6_pipeline_ctrl.sv
module tb_cpu6_pipeline_ctrl;

   localparam int XLEN        = 32;
   localparam int RFIDX_WIDTH = 5;

   // Expected control vector bit order:
   // {stallF, stallD, stallE, flashD, flashE, flashM, redirect_valid, busy}
   localparam logic [7:0] V_QUIET   = 8'b0000_0000;
   localparam logic [7:0] V_LUSE    = 8'b1100_1000;
   localparam logic [7:0] V_JUMP    = 8'b0001_1010;
   localparam logic [7:0] V_REQ     = 8'b1001_1100;
   localparam logic [7:0] V_DRAIN   = 8'b1001_1101;
   localparam logic [7:0] V_REDIR   = 8'b0001_0011;
   localparam logic [7:0] V_MB_IDLE = 8'b1110_0000;
   localparam logic [7:0] V_MB_SEQ  = 8'b1110_0001;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [RFIDX_WIDTH-1:0] rs1D, rs2D, writeregE;
   logic                   memtoregE, jumpE, empty_pipeline_reqM, mem_busy;
   logic [XLEN-1:0]        jump_targetE, pcplus4M;
   logic                   stallF, stallD, stallE, flashD, flashE, flashM;
   logic                   redirect_valid, busy;
   logic [XLEN-1:0]        redirect_pc;

   logic [39:0] exp_q[$];
   int          id_q[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   cpu6_pipeline_ctrl #(.XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH), .DRAIN_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .memtoregE(memtoregE),
      .writeregE(writeregE), .jumpE(jumpE), .jump_targetE(jump_targetE),
      .empty_pipeline_reqM(empty_pipeline_reqM), .pcplus4M(pcplus4M),
      .mem_busy(mem_busy), .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .flashD(flashD), .flashE(flashE), .flashM(flashM),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   task automatic quiet_inputs();
      rs1D = '0; rs2D = '0; writeregE = '0; memtoregE = 1'b0; jumpE = 1'b0;
      jump_targetE = '0; empty_pipeline_reqM = 1'b0; pcplus4M = '0; mem_busy = 1'b0;
   endtask

   task automatic push(input int id, input logic [7:0] ev, input logic [31:0] epc);
      exp_q.push_back({ev, epc});
      id_q.push_back(id);
   endtask

   task automatic pop_check();
      logic [39:0] e, o;
      int id;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty observed=none expected=entry");
      end else begin
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         o  = {stallF, stallD, stallE, flashD, flashE, flashM, redirect_valid, busy, redirect_pc};
         assert (o === e) else begin
            bad++;
            $error("FAIL step%0d observed vec=%b pc=%h expected vec=%b pc=%h",
                   id, o[39:32], o[31:0], e[39:32], e[31:0]);
         end
      end
   endtask

   // Inputs are already set just after a rising edge; sample at the falling edge.
   task automatic cyc(input int id, input logic [7:0] ev, input logic [31:0] epc);
      push(id, ev, epc);
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet_inputs();
      reset = 1'b1;
      #2;
      push(0, V_QUIET, 32'h0); pop_check();
      // Hazard present while reset is held: outputs stay quiet.
      memtoregE = 1'b1; writeregE = 5'd5; rs2D = 5'd5;
      #1;
      push(1, V_QUIET, 32'h0); pop_check();
      quiet_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(2, V_QUIET, 32'h0);

      // Load-use on rs2, then on rs1, then a load to x0.
      memtoregE = 1'b1; writeregE = 5'd5; rs2D = 5'd5; rs1D = 5'd3;
      cyc(10, V_LUSE, 32'h0);
      memtoregE = 1'b0;
      cyc(11, V_QUIET, 32'h0);
      memtoregE = 1'b1; writeregE = 5'd7; rs1D = 5'd7; rs2D = 5'd1;
      cyc(12, V_LUSE, 32'h0);
      writeregE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
      cyc(13, V_QUIET, 32'h0);
      writeregE = 5'd9; rs1D = 5'd8; rs2D = 5'd10;
      cyc(14, V_QUIET, 32'h0);

      // Jump with a simultaneous load-use.
      writeregE = 5'd5; rs2D = 5'd5; jumpE = 1'b1; jump_targetE = 32'h0000_0100;
      cyc(20, V_JUMP, 32'h0000_0100);
      quiet_inputs();
      cyc(21, V_QUIET, 32'h0);

      // Empty pipeline; pcplus4M changes after capture.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0204;
      cyc(30, V_REQ, 32'h0);
      pcplus4M = 32'h0000_0999;
      cyc(31, V_DRAIN, 32'h0);
      empty_pipeline_reqM = 1'b0;
      cyc(32, V_DRAIN, 32'h0);
      cyc(33, V_REDIR, 32'h0000_0204);
      cyc(34, V_QUIET, 32'h0);

      // Request together with a jump: the jump is ignored.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0080;
      jumpE = 1'b1; jump_targetE = 32'h0000_0300;
      cyc(40, V_REQ, 32'h0);
      quiet_inputs();
      cyc(41, V_DRAIN, 32'h0);
      cyc(42, V_DRAIN, 32'h0);
      cyc(43, V_REDIR, 32'h0000_0080);
      cyc(44, V_QUIET, 32'h0);

      // mem_busy for 3 cycles inside DRAIN delays the redirect by 3.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0400;
      cyc(50, V_REQ, 32'h0);
      empty_pipeline_reqM = 1'b0;
      cyc(51, V_DRAIN, 32'h0);
      mem_busy = 1'b1;
      for (int k = 0; k < 3; k++) cyc(52 + k, V_MB_SEQ, 32'h0);
      mem_busy = 1'b0;
      cyc(55, V_DRAIN, 32'h0);
      cyc(56, V_REDIR, 32'h0000_0400);
      cyc(57, V_QUIET, 32'h0);

      // Request held off while mem_busy, accepted after release.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0500; mem_busy = 1'b1;
      cyc(60, V_MB_IDLE, 32'h0);
      cyc(61, V_MB_IDLE, 32'h0);
      mem_busy = 1'b0; pcplus4M = 32'h0000_0504;
      cyc(62, V_REQ, 32'h0);
      empty_pipeline_reqM = 1'b0;
      cyc(63, V_DRAIN, 32'h0);
      cyc(64, V_DRAIN, 32'h0);
      cyc(65, V_REDIR, 32'h0000_0504);
      cyc(66, V_QUIET, 32'h0);

      // mem_busy during REDIRECT suppresses it until release.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0600;
      cyc(70, V_REQ, 32'h0);
      empty_pipeline_reqM = 1'b0;
      cyc(71, V_DRAIN, 32'h0);
      cyc(72, V_DRAIN, 32'h0);
      mem_busy = 1'b1;
      cyc(73, V_MB_SEQ, 32'h0);
      mem_busy = 1'b0;
      cyc(74, V_REDIR, 32'h0000_0600);
      cyc(75, V_QUIET, 32'h0);

      // Asynchronous reset in the middle of DRAIN.
      empty_pipeline_reqM = 1'b1; pcplus4M = 32'h0000_0700;
      cyc(80, V_REQ, 32'h0);
      empty_pipeline_reqM = 1'b0;
      cyc(81, V_DRAIN, 32'h0);
      reset = 1'b1;
      #1;
      push(82, V_QUIET, 32'h0); pop_check();
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) cyc(83 + k, V_QUIET, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu6_pipeline_ctrl.md
Name: cpu6_pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the cpu6 5-stage pipeline.
- Generates the stall and flash (flush) controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles load-use stalls, jump redirects, data-memory back-pressure and the empty-pipeline sequence requested by CSR/serialising instructions in MEM.
- Sits beside the datapath. It consumes hazard sources from the D/E/M stages and drives stallF/stallD/flashD/flashE/flashM plus the fetch redirect.

Parameters:
- XLEN, 32, datapath/PC width (matches CPU6_XLEN).
- RFIDX_WIDTH, 5, register index width (matches CPU6_RFIDX_WIDTH).
- DRAIN_CYCLES, 2, cycles to wait after an empty-pipeline request before refetch; legal 1..15, 0 treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1D  in  RFIDX_WIDTH  rs1 index of instruction in D.
- rs2D  in  RFIDX_WIDTH  rs2 index of instruction in D.
- memtoregE  in  1  instruction in E is a load.
- writeregE  in  RFIDX_WIDTH  destination of instruction in E.
- jumpE  in  1  taken jump/branch resolved in E.
- jump_targetE  in  XLEN  target for jumpE.
- empty_pipeline_reqM  in  1  serialising instruction is in MEM.
- pcplus4M  in  XLEN  pc+4 of the MEM instruction.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID register.
- stallE  out  1  hold ID/EX register.
- flashD  out  1  clear IF/ID input.
- flashE  out  1  clear ID/EX input.
- flashM  out  1  clear EX/MEM input.
- redirect_valid  out  1  load PC from redirect_pc this cycle.
- redirect_pc  out  XLEN  new fetch address.
- busy  out  1  empty-pipeline sequence in progress.

Behaviour:
- Reset (async): FSM=IDLE, counter=0, saved PC=0. All outputs 0 while reset is asserted and in the first cycle after release unless an input hazard applies.
- Load-use hazard, combinational: luse = memtoregE & (writeregE!=0) & (writeregE==rs1D | writeregE==rs2D).
- Priority, highest first: mem_busy, DRAIN/REDIRECT state, jumpE, luse.
- mem_busy=1:
  - stallF=stallD=stallE=1, all flash=0, redirect_valid=0.
  - FSM state and counter hold.
  - An empty_pipeline_reqM seen during mem_busy is not accepted until mem_busy drops.
- IDLE with empty_pipeline_reqM=1 and mem_busy=0:
  - Same cycle: flashD=flashE=flashM=1, stallF=1. This kills the E, D and F instructions; the MEM instruction continues to WB.
  - Capture pcplus4M, load counter=max(DRAIN_CYCLES,1), go to DRAIN. busy=1 from the next cycle.
  - Overrides a simultaneous jumpE (the jump is younger) and luse.
- DRAIN:
  - stallF=1, flashD=flashE=flashM=1, busy=1.
  - Counter decrements each non-busy cycle; at 1, go to REDIRECT.
  - empty_pipeline_reqM is ignored, since flashed bubbles cannot raise it.
- REDIRECT, exactly one cycle:
  - redirect_valid=1, redirect_pc=saved PC, flashD=1, stallF=0, busy=1.
  - Then go to IDLE.
  - If mem_busy is asserted in REDIRECT, redirect_valid is forced to 0 and the state holds until mem_busy drops.
- IDLE, jumpE=1: redirect_valid=1, redirect_pc=jump_targetE, flashD=1, flashE=1, no stall. Overrides luse because the D instruction is wrong-path.
- IDLE, luse=1 and no jumpE: stallF=1, stallD=1, flashE=1 (bubble into E), for exactly one cycle per hazard.
- redirect_pc is 0 whenever redirect_valid=0.
- Total empty-pipeline latency: request cycle + DRAIN_CYCLES + 1 redirect cycle, assuming no mem_busy.
- Reset mid-sequence aborts to IDLE immediately with no redirect issued.
- All FSM/counter flops use async-reset DFFs; outputs are combinational from state and inputs.

Test Plan:
- Load-use: memtoregE=1, writeregE=5, rs2D=5 -> stallF=stallD=flashE=1 for 1 cycle. Repeat with writeregE=0 -> no stall.
- Jump: jumpE=1, jump_targetE=0x0000_0100 with luse also true -> redirect_valid=1, redirect_pc=0x100, flashD=flashE=1, stallF=0.
- Empty pipeline, DRAIN_CYCLES=2: empty_pipeline_reqM=1, pcplus4M=0x0000_0204 at cycle T.
  - Flash all in T, T+1, T+2.
  - redirect_valid=1 with redirect_pc=0x204 in T+3.
  - busy=1 T+1..T+3, IDLE at T+4.
- Simultaneous empty_pipeline_reqM and jumpE (target 0x300), pcplus4M=0x80 -> jump ignored, eventual redirect_pc=0x80.
- mem_busy asserted 3 cycles during DRAIN -> all stalls=1, counter frozen, redirect delayed exactly 3 cycles. mem_busy high at the request cycle -> request not accepted until release.
- Assert reset asynchronously mid-DRAIN -> outputs 0 without waiting for a clk edge, no redirect after release, FSM in IDLE.
